// File: rtl/alu_share_if.sv
// Bundle of both requester ports, the registered result port and the grant
// counters shared between alu_share_arbiter (slave) and its environment (master).
interface alu_share_if #(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
);
  // Handshake: a transfer happens on a rising edge where valid & ready are both 1.
  // A producer holds valid and its payload stable until ready; ready may depend on valid.
  logic             req0_valid;
  logic             req0_ready;
  logic [31:0]      req0_a;
  logic [31:0]      req0_b;
  logic [3:0]       req0_op;
  logic [TAG_W-1:0] req0_tag;

  logic             req1_valid;
  logic             req1_ready;
  logic [31:0]      req1_a;
  logic [31:0]      req1_b;
  logic [3:0]       req1_op;
  logic [TAG_W-1:0] req1_tag;

  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic             out_z;
  logic             out_n;
  logic             out_c;
  logic             out_v;
  logic             out_src;
  logic [TAG_W-1:0] out_tag;

  logic             cnt_clr;
  logic [CNT_W-1:0] grant_cnt0;
  logic [CNT_W-1:0] grant_cnt1;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op, req0_tag,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_op, req1_tag,
    output req1_ready,
    output out_valid, out_result, out_z, out_n, out_c, out_v, out_src, out_tag,
    input  out_ready,
    input  cnt_clr,
    output grant_cnt0, grant_cnt1
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op, req0_tag,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_op, req1_tag,
    input  req1_ready,
    input  out_valid, out_result, out_z, out_n, out_c, out_v, out_src, out_tag,
    output out_ready,
    output cnt_clr,
    input  grant_cnt0, grant_cnt1
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// One 32-bit ALU shared round-robin between the integer pipeline (port 0) and the
// address/branch unit (port 1), with a single registered result stage and grant counters.
module alu_share_arbiter #(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input logic        clk,
  input logic        rst_n,
  alu_share_if.slave bus
);
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             r_out_valid;
  logic [31:0]      r_out_result;
  logic             r_out_z, r_out_n, r_out_c, r_out_v;
  logic             r_out_src;
  logic [TAG_W-1:0] r_out_tag;
  logic             r_last_grant;
  logic [CNT_W-1:0] r_cnt0, r_cnt1;

  logic        w_can_accept;
  logic        w_any;
  logic        w_grant;
  logic        w_xfer;
  logic [31:0] w_a, w_b;
  logic [3:0]  w_op;
  logic [32:0] w_sum;
  logic [31:0] w_alu_res;
  logic        w_alu_c, w_alu_v, w_alu_z, w_alu_n;

  // Result slot frees up in the same cycle it drains, so no bubble under load.
  assign w_can_accept = ~r_out_valid | bus.out_ready;
  assign w_any        = bus.req0_valid | bus.req1_valid;
  assign w_grant      = (bus.req0_valid & bus.req1_valid) ? ~r_last_grant : bus.req1_valid;
  assign w_xfer       = w_can_accept & w_any;

  assign bus.req0_ready = w_can_accept & ~w_grant & bus.req0_valid;
  assign bus.req1_ready = w_can_accept &  w_grant & bus.req1_valid;

  assign w_a  = w_grant ? bus.req1_a  : bus.req0_a;
  assign w_b  = w_grant ? bus.req1_b  : bus.req0_b;
  assign w_op = w_grant ? bus.req1_op : bus.req0_op;

  // C follows the carry-out convention: for SUB, C=1 means no borrow.
  always_comb begin
    w_sum     = '0;
    w_alu_res = '0;
    w_alu_c   = 1'b0;
    w_alu_v   = 1'b0;
    case (w_op)
      OP_ADD: begin
        w_sum     = {1'b0, w_a} + {1'b0, w_b};
        w_alu_res = w_sum[31:0];
        w_alu_c   = w_sum[32];
        w_alu_v   = (w_a[31] == w_b[31]) && (w_sum[31] != w_a[31]);
      end
      OP_SUB: begin
        w_sum     = {1'b0, w_a} + {1'b0, ~w_b} + 33'd1;
        w_alu_res = w_sum[31:0];
        w_alu_c   = w_sum[32];
        w_alu_v   = (w_a[31] != w_b[31]) && (w_sum[31] != w_a[31]);
      end
      OP_AND:  w_alu_res = w_a & w_b;
      OP_OR:   w_alu_res = w_a | w_b;
      OP_XOR:  w_alu_res = w_a ^ w_b;
      OP_SLL:  w_alu_res = w_a << w_b[4:0];
      OP_SRL:  w_alu_res = w_a >> w_b[4:0];
      OP_SRA:  w_alu_res = $unsigned($signed(w_a) >>> w_b[4:0]);
      OP_SLT:  w_alu_res = {31'd0, ($signed(w_a) < $signed(w_b))};
      OP_SLTU: w_alu_res = {31'd0, (w_a < w_b)};
      default: w_alu_res = '0;
    endcase
  end

  assign w_alu_z = (w_alu_res == 32'd0);
  assign w_alu_n = w_alu_res[31];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_z      <= 1'b0;
      r_out_n      <= 1'b0;
      r_out_c      <= 1'b0;
      r_out_v      <= 1'b0;
      r_out_src    <= 1'b0;
      r_out_tag    <= '0;
      r_last_grant <= 1'b1;
    end else if (w_xfer) begin
      r_out_valid  <= 1'b1;
      r_out_result <= w_alu_res;
      r_out_z      <= w_alu_z;
      r_out_n      <= w_alu_n;
      r_out_c      <= w_alu_c;
      r_out_v      <= w_alu_v;
      r_out_src    <= w_grant;
      r_out_tag    <= w_grant ? bus.req1_tag : bus.req0_tag;
      r_last_grant <= w_grant;
    end else if (bus.out_ready) begin
      r_out_valid  <= 1'b0;
    end
  end

  // Clear has priority over a same-cycle increment; counters stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else if (bus.cnt_clr) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else if (w_xfer) begin
      if (!w_grant && r_cnt0 != CNT_MAX) r_cnt0 <= r_cnt0 + 1'b1;
      if ( w_grant && r_cnt1 != CNT_MAX) r_cnt1 <= r_cnt1 + 1'b1;
    end
  end

  assign bus.out_valid  = r_out_valid;
  assign bus.out_result = r_out_result;
  assign bus.out_z      = r_out_z;
  assign bus.out_n      = r_out_n;
  assign bus.out_c      = r_out_c;
  assign bus.out_v      = r_out_v;
  assign bus.out_src    = r_out_src;
  assign bus.out_tag    = r_out_tag;
  assign bus.grant_cnt0 = r_cnt0;
  assign bus.grant_cnt1 = r_cnt1;
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one 32-bit ALU instance (v_alu, combinational, alu_op codes from constant_def.vh) between two requesters: port 0 is the integer pipeline and port 1 is the address/branch unit.
- Round-robin arbitration picks one operation per cycle.
- The ALU output and flags are captured in a single registered output stage with a valid/ready handshake.
- Saturating per-port grant counters support performance monitoring.

Parameters:
- TAG_W, 4, width of the opaque requester tag carried through with each operation.
- CNT_W, 16, width of each saturating grant counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  port 0 has an operation.
- req0_ready  out  1  port 0 operation accepted this cycle.
- req0_a, req0_b  in  32  port 0 operands.
- req0_op  in  4  port 0 alu_op.
- req0_tag  in  TAG_W  port 0 tag.
- req1_valid, req1_ready, req1_a, req1_b, req1_op, req1_tag: same as port 0, for port 1.
- out_valid  out  1  result register holds a valid result.
- out_ready  in  1  consumer accepts the result.
- out_result  out  32  registered ALU result.
- out_z, out_n, out_c, out_v  out  1 each  registered flags.
- out_src  out  1  port that issued the result.
- out_tag  out  TAG_W  tag of that operation.
- cnt_clr  in  1  synchronous clear of both grant counters.
- grant_cnt0, grant_cnt1  out  CNT_W  accepted-operation counts per port.

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0; out_result=0; all flags 0; out_src=0; out_tag=0.
  - grant_cnt0 = grant_cnt1 = 0.
  - last_grant=1, so port 0 wins the first contention.
- Accept condition: can_accept = ~out_valid | out_ready. This is combinational, so a full register accepts a new operation in the same cycle the old result drains. There is no bubble: sustained throughput is 1 op/cycle.
- Arbitration (combinational, one grant per cycle):
  - Only req0_valid: grant 0.
  - Only req1_valid: grant 1.
  - Both valid: grant the port != last_grant.
  - Neither valid: no grant.
- Ready outputs:
  - reqK_ready = can_accept & grant==K & reqK_valid.
  - The ungranted port sees ready=0.
  - A requester must hold valid, operands, op and tag stable until ready.
- ALU inputs mux: A, B and op come from the granted port. With no grant the mux selects port 0; the result is unused.
- Transfer cycle (any reqK_valid & reqK_ready), at the clock edge:
  - out_result and flags load from the ALU outputs.
  - out_src=K; out_tag=reqK_tag; out_valid=1.
  - last_grant=K.
  - grant_cntK increments.
- Latency: an operation accepted in cycle N has its result visible with out_valid=1 in cycle N+1.
- Drain with no new transfer: out_valid & out_ready & no transfer → out_valid=0 next cycle. Data registers hold their last values (don't-care).
- Stall: out_valid=1 & out_ready=0 → all output registers hold; both reqK_ready=0; last_grant holds.
- last_grant updates only on an actual transfer. A stalled grant does not rotate priority.
- Counters:
  - Saturate at 2^CNT_W-1 and do not wrap.
  - If cnt_clr=1 and a transfer occur in the same cycle, the clear wins: the counter becomes 0, not 1.
  - cnt_clr does not affect any other state.
- Unknown alu_op: the ALU itself returns result 0 and flags Z=1, N=0, C=0, V=0. The arbiter passes this through unchanged; there is no error path.
- Reset asserted mid-transfer or mid-stall: all state clears immediately. The in-flight result is dropped, and the requester must re-present its operation.

Test Plan:
- Reset, then req0 ADD a=5, b=7, tag=3, out_ready=1 → req0_ready=1 in cycle 0; cycle 1 out_valid=1, out_result=12, Z=N=C=V=0, out_src=0, out_tag=3; grant_cnt0=1.
- Both valid every cycle, out_ready=1: req0 SUB a=0, b=1; req1 ADD a=0x7FFFFFFF, b=1 → grants alternate 0,1,0,1. Port 0 results 0xFFFFFFFF with N=1, C=0. Port 1 results 0x80000000 with N=1, V=1.
- Backpressure: result pending, out_ready=0 for 3 cycles with both ports valid → both readys=0 and outputs stable for all 3 cycles. Then out_ready=1 → the next operation is accepted that same cycle and appears on the following cycle without a bubble; the grant order is unchanged by the stall.
- Counter saturation, CNT_W=4: 20 transfers on port 1 → grant_cnt1=15. Then cnt_clr pulsed together with a transfer → grant_cnt1=0.
- Async reset asserted while out_valid=1 and stalled → out_valid=0 immediately, counters 0. After release, with both ports valid, port 0 wins first.
